// File: rtl/fabric_pll_lock_ctrl.sv
// Per-channel PLL reset/lock sequencer: reset pulse, lock wait with timeout/retry, lock qualification.
// Define FABRIC_PLL_LOL_COUNT_EN to build the per-channel loss-of-lock counters and the lol_count port.
module fabric_pll_lock_ctrl #(
  parameter int unsigned NUM_PLLS       = 2,
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic [NUM_PLLS-1:0]   chan_en,
  input  logic [NUM_PLLS-1:0]   force_rst,
  input  logic [NUM_PLLS-1:0]   pll_locked_in,
  output logic [NUM_PLLS-1:0]   pll_rst,
  output logic [NUM_PLLS-1:0]   locked,
  output logic                  all_locked,
  output logic [NUM_PLLS-1:0]   fail
`ifdef FABRIC_PLL_LOL_COUNT_EN
  ,
  output logic [8*NUM_PLLS-1:0] lol_count
`endif
);

  localparam int unsigned RW  = $clog2(RST_CYCLES) + 1;
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned SW  = $clog2(STABLE_CYCLES) + 1;
  localparam int unsigned RTW = $clog2(MAX_RETRIES) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_WAIT, S_STABLE, S_LOCKED, S_FAILED
  } state_t;

  for (genvar i = 0; i < NUM_PLLS; i++) begin : g_chan
    state_t         state;
    logic [1:0]     sync;
    logic [RW-1:0]  rst_cnt;
    logic [TW-1:0]  tmr;
    logic [SW-1:0]  stb_cnt;
    logic [RTW-1:0] retry;
    logic           rst_q;
    logic           lck_q;
    logic           fail_q;
    logic           lock;

    assign lock       = sync[1];
    assign pll_rst[i] = rst_q;
    assign locked[i]  = lck_q;
    assign fail[i]    = fail_q;

    // Channel sequencer; outputs are registered alongside each state transition.
    always_ff @(posedge refclk) begin
      if (!rst_n) begin
        sync    <= 2'b00;
        state   <= S_IDLE;
        rst_cnt <= '0;
        tmr     <= '0;
        stb_cnt <= '0;
        retry   <= '0;
        rst_q   <= 1'b1;
        lck_q   <= 1'b0;
        fail_q  <= 1'b0;
      end else begin
        sync <= {sync[0], pll_locked_in[i]};
        if (!chan_en[i]) begin
          state   <= S_IDLE;
          rst_cnt <= '0;
          tmr     <= '0;
          stb_cnt <= '0;
          retry   <= '0;
          rst_q   <= 1'b1;
          lck_q   <= 1'b0;
          fail_q  <= 1'b0;
        end else if (force_rst[i] && (state != S_IDLE)) begin
          state   <= S_RESET;
          rst_cnt <= '0;
          tmr     <= '0;
          stb_cnt <= '0;
          retry   <= '0;
          rst_q   <= 1'b1;
          lck_q   <= 1'b0;
          fail_q  <= 1'b0;
        end else begin
          case (state)
            S_IDLE: begin
              state   <= S_RESET;
              rst_cnt <= '0;
              retry   <= '0;
              rst_q   <= 1'b1;
              lck_q   <= 1'b0;
              fail_q  <= 1'b0;
            end
            S_RESET: begin
              if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                state <= S_WAIT;
                tmr   <= '0;
                rst_q <= 1'b0;
              end else begin
                rst_cnt <= rst_cnt + RW'(1);
              end
            end
            S_WAIT: begin
              if (lock) begin
                state   <= S_STABLE;
                stb_cnt <= '0;
              end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
                rst_q <= 1'b1;
                if (retry < RTW'(MAX_RETRIES)) begin
                  state   <= S_RESET;
                  rst_cnt <= '0;
                  retry   <= retry + RTW'(1);
                end else begin
                  state  <= S_FAILED;
                  fail_q <= 1'b1;
                end
              end else begin
                tmr <= tmr + TW'(1);
              end
            end
            S_STABLE: begin
              if (!lock) begin
                state <= S_WAIT;
                tmr   <= '0;
              end else if (stb_cnt == SW'(STABLE_CYCLES - 1)) begin
                state <= S_LOCKED;
                retry <= '0;
                lck_q <= 1'b1;
              end else begin
                stb_cnt <= stb_cnt + SW'(1);
              end
            end
            S_LOCKED: begin
              // Loss of lock restarts the PLL without consuming a retry.
              if (!lock) begin
                state   <= S_RESET;
                rst_cnt <= '0;
                rst_q   <= 1'b1;
                lck_q   <= 1'b0;
              end
            end
            S_FAILED: begin
              rst_q  <= 1'b1;
              fail_q <= 1'b1;
            end
            default: begin
              state  <= S_IDLE;
              rst_q  <= 1'b1;
              lck_q  <= 1'b0;
              fail_q <= 1'b0;
            end
          endcase
        end
      end
    end

`ifdef FABRIC_PLL_LOL_COUNT_EN
    logic [7:0] lol;
    assign lol_count[8*i +: 8] = lol;

    // Counts only the LOCKED->RESET transition taken on loss of lock; saturates.
    always_ff @(posedge refclk) begin
      if (!rst_n) begin
        lol <= 8'd0;
      end else if (chan_en[i] && !force_rst[i] && (state == S_LOCKED) && !lock && (lol != 8'hff)) begin
        lol <= lol + 8'd1;
      end
    end
`endif
  end

  // Lags the per-channel locked flags by one cycle.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      all_locked <= 1'b0;
    end else begin
      all_locked <= (|chan_en) && (&(locked | ~chan_en));
    end
  end

endmodule

// File: tb/tb_fabric_pll_lock_ctrl.sv
// Self-checking bench for fabric_pll_lock_ctrl: directed timing scenarios with randomized delays
// plus a randomized enable/force run checked against an age-based behavioural model.
module tb_fabric_pll_lock_ctrl;
  localparam int unsigned NUM_PLLS       = 2;
  localparam int unsigned RST_CYCLES     = 4;
  localparam int unsigned STABLE_CYCLES  = 8;
  localparam int unsigned TIMEOUT_CYCLES = 32;
  localparam int unsigned MAX_RETRIES    = 2;

  localparam int LOCK_LAT    = 2 + STABLE_CYCLES + 1;
  localparam int ENABLE_LOCK = 1 + RST_CYCLES + 1 + STABLE_CYCLES;
  localparam int SEL_LOCKED  = 0;
  localparam int SEL_RST     = 1;
  localparam int SEL_FAIL    = 2;

  logic                refclk = 1'b0;
  logic                rst_n;
  logic [NUM_PLLS-1:0] chan_en;
  logic [NUM_PLLS-1:0] force_rst;
  logic [NUM_PLLS-1:0] pll_locked_in;
  logic [NUM_PLLS-1:0] pll_rst;
  logic [NUM_PLLS-1:0] locked;
  logic                all_locked;
  logic [NUM_PLLS-1:0] fail;
`ifdef FABRIC_PLL_LOL_COUNT_EN
  logic [8*NUM_PLLS-1:0] lol_count;
`endif

  int checks = 0;
  int errors = 0;

  fabric_pll_lock_ctrl #(
    .NUM_PLLS(NUM_PLLS), .RST_CYCLES(RST_CYCLES), .STABLE_CYCLES(STABLE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .chan_en(chan_en), .force_rst(force_rst),
    .pll_locked_in(pll_locked_in), .pll_rst(pll_rst), .locked(locked),
    .all_locked(all_locked), .fail(fail)
`ifdef FABRIC_PLL_LOL_COUNT_EN
    , .lol_count(lol_count)
`endif
  );

  always #5 refclk = ~refclk;

  task automatic step(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // Returns the number of cycles until the selected output reaches val, or -1 if the bound expires.
  task automatic wait_sig(input int sel, input int ch, input logic val, input int limit, output int n);
    logic s;
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge refclk);
      case (sel)
        SEL_LOCKED: s = locked[ch];
        SEL_RST:    s = pll_rst[ch];
        SEL_FAIL:   s = fail[ch];
        default:    s = all_locked;
      endcase
      if (s === val) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    chan_en = '0;
    force_rst = '0;
    pll_locked_in = '0;
    step(3);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    chan_en = '1;
    force_rst = '0;
    pll_locked_in = '1;
    step(3);
    checks++; if (pll_rst !== 2'b11) begin errors++; $display("FAIL reset_pll_rst: got %b expected 11", pll_rst); end
    checks++; if (locked !== 2'b00) begin errors++; $display("FAIL reset_locked: got %b expected 00", locked); end
    checks++; if (fail !== 2'b00) begin errors++; $display("FAIL reset_fail: got %b expected 00", fail); end
    checks++; if (all_locked !== 1'b0) begin errors++; $display("FAIL reset_all_locked: got %b expected 0", all_locked); end
`ifdef FABRIC_PLL_LOL_COUNT_EN
    checks++; if (lol_count !== 16'h0) begin errors++; $display("FAIL reset_lol: got %h expected 0000", lol_count); end
`endif
  endtask

  task automatic test_lock_basic;
    int ch, d, n;
    ch = int'($urandom_range(0, 1));
    d = int'($urandom_range(0, 25));
    do_reset();
    chan_en[ch] = 1'b1;
    wait_sig(SEL_RST, ch, 1'b0, 50, n);
    checks++; if (n !== 1 + RST_CYCLES) begin errors++; $display("FAIL basic_reset_len ch%0d: got %0d expected %0d", ch, n, 1 + RST_CYCLES); end
    step(d);
    pll_locked_in[ch] = 1'b1;
    wait_sig(SEL_LOCKED, ch, 1'b1, 100, n);
    checks++; if (n !== LOCK_LAT) begin errors++; $display("FAIL basic_lock_lat ch%0d d=%0d: got %0d expected %0d", ch, d, n, LOCK_LAT); end
    checks++; if (pll_rst[1-ch] !== 1'b1 || locked[1-ch] !== 1'b0) begin
      errors++; $display("FAIL basic_idle_other: got rst=%b lck=%b expected 1 0", pll_rst[1-ch], locked[1-ch]);
    end
    step(1);
    checks++; if (all_locked !== 1'b1) begin errors++; $display("FAIL basic_all_locked: got %b expected 1", all_locked); end
  endtask

  task automatic test_stable_glitch;
    int ch, g, n;
    ch = int'($urandom_range(0, 1));
    g = int'($urandom_range(1, 8));
    do_reset();
    chan_en[ch] = 1'b1;
    wait_sig(SEL_RST, ch, 1'b0, 50, n);
    pll_locked_in[ch] = 1'b1;
    step(g);
    pll_locked_in[ch] = 1'b0;
    step(1);
    pll_locked_in[ch] = 1'b1;
    wait_sig(SEL_LOCKED, ch, 1'b1, 100, n);
    checks++; if (n !== LOCK_LAT) begin errors++; $display("FAIL glitch_relock_lat ch%0d g=%0d: got %0d expected %0d", ch, g, n, LOCK_LAT); end
  endtask

  task automatic test_timeout;
    int ch, n;
    ch = int'($urandom_range(0, 1));
    do_reset();
    chan_en[ch] = 1'b1;
    wait_sig(SEL_RST, ch, 1'b0, 50, n);
    checks++; if (n !== 1 + RST_CYCLES) begin errors++; $display("FAIL to_first_reset: got %0d expected %0d", n, 1 + RST_CYCLES); end
    for (int pass = 0; pass < 2; pass++) begin
      for (int a = 0; a < int'(MAX_RETRIES); a++) begin
        wait_sig(SEL_RST, ch, 1'b1, 100, n);
        checks++; if (n !== TIMEOUT_CYCLES) begin errors++; $display("FAIL to_wait_len p%0d a%0d: got %0d expected %0d", pass, a, n, TIMEOUT_CYCLES); end
        checks++; if (fail[ch] !== 1'b0) begin errors++; $display("FAIL to_early_fail p%0d a%0d: got %b expected 0", pass, a, fail[ch]); end
        wait_sig(SEL_RST, ch, 1'b0, 50, n);
        checks++; if (n !== RST_CYCLES) begin errors++; $display("FAIL to_pulse_len p%0d a%0d: got %0d expected %0d", pass, a, n, RST_CYCLES); end
      end
      wait_sig(SEL_FAIL, ch, 1'b1, 100, n);
      checks++; if (n !== TIMEOUT_CYCLES) begin errors++; $display("FAIL to_fail_time p%0d: got %0d expected %0d", pass, n, TIMEOUT_CYCLES); end
      step(10);
      checks++; if (fail[ch] !== 1'b1 || pll_rst[ch] !== 1'b1) begin
        errors++; $display("FAIL to_failed_hold p%0d: got fail=%b rst=%b expected 1 1", pass, fail[ch], pll_rst[ch]);
      end
      force_rst[ch] = 1'b1;
      step(1);
      force_rst[ch] = 1'b0;
      checks++; if (fail[ch] !== 1'b0 || pll_rst[ch] !== 1'b1) begin
        errors++; $display("FAIL to_force_exit p%0d: got fail=%b rst=%b expected 0 1", pass, fail[ch], pll_rst[ch]);
      end
      wait_sig(SEL_RST, ch, 1'b0, 50, n);
      checks++; if (n !== RST_CYCLES) begin errors++; $display("FAIL to_force_pulse p%0d: got %0d expected %0d", pass, n, RST_CYCLES); end
    end
    chan_en[ch] = 1'b0;
    step(1);
    checks++; if (fail[ch] !== 1'b0 || pll_rst[ch] !== 1'b1) begin
      errors++; $display("FAIL to_disable: got fail=%b rst=%b expected 0 1", fail[ch], pll_rst[ch]);
    end
  endtask

  task automatic test_lol;
    int ch, n;
    ch = int'($urandom_range(0, 1));
    do_reset();
    chan_en[ch] = 1'b1;
    pll_locked_in[ch] = 1'b1;
    wait_sig(SEL_LOCKED, ch, 1'b1, 100, n);
    checks++; if (n !== ENABLE_LOCK) begin errors++; $display("FAIL lol_first_lock: got %0d expected %0d", n, ENABLE_LOCK); end
    step(int'($urandom_range(0, 10)));
    pll_locked_in[ch] = 1'b0;
    wait_sig(SEL_LOCKED, ch, 1'b0, 20, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL lol_unlock_lat: got %0d expected 3", n); end
    checks++; if (pll_rst[ch] !== 1'b1) begin errors++; $display("FAIL lol_rst_rise: got %b expected 1", pll_rst[ch]); end
    pll_locked_in[ch] = 1'b1;
    wait_sig(SEL_RST, ch, 1'b0, 50, n);
    checks++; if (n !== RST_CYCLES) begin errors++; $display("FAIL lol_pulse_len: got %0d expected %0d", n, RST_CYCLES); end
    wait_sig(SEL_LOCKED, ch, 1'b1, 100, n);
    checks++; if (n !== 1 + STABLE_CYCLES) begin errors++; $display("FAIL lol_relock: got %0d expected %0d", n, 1 + STABLE_CYCLES); end
`ifdef FABRIC_PLL_LOL_COUNT_EN
    checks++; if (lol_count[8*ch +: 8] !== 8'd1 || lol_count[8*(1-ch) +: 8] !== 8'd0) begin
      errors++; $display("FAIL lol_count_one ch%0d: got %h expected 1 on ch%0d only", ch, lol_count, ch);
    end
    force_rst[ch] = 1'b1;
    step(1);
    force_rst[ch] = 1'b0;
    chan_en[ch] = 1'b0;
    step(2);
    chan_en[ch] = 1'b1;
    checks++; if (lol_count[8*ch +: 8] !== 8'd1) begin errors++; $display("FAIL lol_count_hold: got %0d expected 1", lol_count[8*ch +: 8]); end
    begin
      int timeouts = 0;
      for (int k = 0; k < 256; k++) begin
        wait_sig(SEL_LOCKED, ch, 1'b1, 100, n);
        if (n < 0) timeouts++;
        pll_locked_in[ch] = 1'b0;
        wait_sig(SEL_LOCKED, ch, 1'b0, 20, n);
        if (n < 0) timeouts++;
        pll_locked_in[ch] = 1'b1;
      end
      checks++; if (timeouts !== 0) begin errors++; $display("FAIL lol_sat_loop: got %0d timeouts expected 0", timeouts); end
    end
    step(2);
    checks++; if (lol_count[8*ch +: 8] !== 8'd255) begin errors++; $display("FAIL lol_count_sat: got %0d expected 255", lol_count[8*ch +: 8]); end
`endif
  endtask

  task automatic test_all_locked;
    int n;
    do_reset();
    chan_en = 2'b01;
    pll_locked_in = 2'b01;
    wait_sig(SEL_LOCKED, 0, 1'b1, 100, n);
    checks++; if (n !== ENABLE_LOCK) begin errors++; $display("FAIL al_lock0: got %0d expected %0d", n, ENABLE_LOCK); end
    checks++; if (all_locked !== 1'b0) begin errors++; $display("FAIL al_lag: got %b expected 0", all_locked); end
    step(1);
    checks++; if (all_locked !== 1'b1) begin errors++; $display("FAIL al_one_chan: got %b expected 1", all_locked); end
    chan_en = 2'b11;
    step(1);
    checks++; if (all_locked !== 1'b0 || locked !== 2'b01) begin
      errors++; $display("FAIL al_two_chan: got all=%b locked=%b expected 0 01", all_locked, locked);
    end
    step(6);
    rst_n = 1'b0;
    step(1);
    checks++; if (pll_rst !== 2'b11 || locked !== 2'b00 || fail !== 2'b00 || all_locked !== 1'b0) begin
      errors++; $display("FAIL al_mid_reset: got rst=%b lck=%b fail=%b all=%b expected 11 00 00 0", pll_rst, locked, fail, all_locked);
    end
    rst_n = 1'b1;
    wait_sig(SEL_LOCKED, 0, 1'b1, 100, n);
    checks++; if (n !== ENABLE_LOCK) begin errors++; $display("FAIL al_after_reset: got %0d expected %0d", n, ENABLE_LOCK); end
  endtask

  // Model: with lock held high, a channel is locked once ENABLE_LOCK-1 edges have passed since its last restart.
  task automatic test_random;
    int   since [NUM_PLLS];
    logic exp_lck [NUM_PLLS];
    logic exp_rst, exp_all;
    do_reset();
    pll_locked_in = '1;
    step(3);
    for (int c = 0; c < int'(NUM_PLLS); c++) begin
      since[c] = -1;
      exp_lck[c] = 1'b0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 23) == 0) chan_en = 2'($urandom);
      force_rst = '0;
      for (int c = 0; c < int'(NUM_PLLS); c++)
        if ($urandom_range(0, 59) == 0) force_rst[c] = 1'b1;
      exp_all = (chan_en != '0);
      for (int c = 0; c < int'(NUM_PLLS); c++)
        if (chan_en[c] && !exp_lck[c]) exp_all = 1'b0;
      for (int c = 0; c < int'(NUM_PLLS); c++) begin
        if (!chan_en[c]) since[c] = -1;
        else if (since[c] < 0 || force_rst[c]) since[c] = 0;
        else since[c]++;
        exp_lck[c] = (since[c] >= ENABLE_LOCK - 1);
      end
      step(1);
      for (int c = 0; c < int'(NUM_PLLS); c++) begin
        exp_rst = (since[c] < int'(RST_CYCLES));
        checks++; if (locked[c] !== exp_lck[c]) begin
          errors++; $display("FAIL rnd_locked cyc%0d ch%0d: got %b expected %b", cyc, c, locked[c], exp_lck[c]);
        end
        checks++; if (pll_rst[c] !== exp_rst) begin
          errors++; $display("FAIL rnd_pll_rst cyc%0d ch%0d: got %b expected %b", cyc, c, pll_rst[c], exp_rst);
        end
        checks++; if (fail[c] !== 1'b0) begin
          errors++; $display("FAIL rnd_fail cyc%0d ch%0d: got %b expected 0", cyc, c, fail[c]);
        end
      end
      checks++; if (all_locked !== exp_all) begin
        errors++; $display("FAIL rnd_all_locked cyc%0d: got %b expected %b", cyc, all_locked, exp_all);
      end
    end
    force_rst = '0;
  endtask

  initial begin
    test_reset();
    test_lock_basic();
    test_stable_glitch();
    test_timeout();
    test_lol();
    test_all_locked();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fabric_pll_lock_ctrl.md
FABRIC_PLL_LOCK_CTRL -- requirements
Module: fabric_pll_lock_ctrl

Interface
REQ-001 Parameter NUM_PLLS, default 2, number of independent PLL channels (1..8).
REQ-002 Parameter RST_CYCLES, default 16, cycles pll_rst is held high per reset attempt (>=1).
REQ-003 Parameter STABLE_CYCLES, default 1024, consecutive synced-lock-high cycles required before a channel reports locked (>=1).
REQ-004 Parameter TIMEOUT_CYCLES, default 65536, cycles allowed in WAIT without lock before a retry (>=2).
REQ-005 Parameter MAX_RETRIES, default 3, timeout retries permitted before FAILED (0..15).
REQ-006 refclk  in  1  single clock for all logic.
REQ-007 rst_n  in  1  synchronous active-low reset, sampled on the refclk rising edge.
REQ-008 chan_en  in  NUM_PLLS  per-channel enable, level.
REQ-009 force_rst  in  NUM_PLLS  per-channel single-cycle restart request.
REQ-010 pll_locked_in  in  NUM_PLLS  raw PLL lock flags, asynchronous to refclk.
REQ-011 pll_rst  out  NUM_PLLS  active-high reset to each PLL.
REQ-012 locked  out  NUM_PLLS  qualified per-channel lock.
REQ-013 all_locked  out  1  every enabled channel locked.
REQ-014 fail  out  NUM_PLLS  channel exhausted retries.
REQ-015 lol_count  out  8*NUM_PLLS  per-channel loss-of-lock counters, channel i in bits [8i+7:8i] (present only per REQ-035).

Function
REQ-016 Each pll_locked_in bit SHALL pass a 2-flop synchroniser; "lock" below means the synchronised value.
REQ-017 Each channel SHALL run an independent FSM with states IDLE, RESET, WAIT, STABLE, LOCKED, FAILED.
REQ-018 IDLE: pll_rst=1, locked=0, fail=0, retry counter=0; chan_en=1 -> RESET.
REQ-019 RESET: pll_rst=1 for exactly RST_CYCLES cycles, then -> WAIT with timeout timer cleared.
REQ-020 WAIT: pll_rst=0; lock=1 -> STABLE; timer reaching TIMEOUT_CYCLES-1 without lock -> RESET with retry+1 if retry<MAX_RETRIES, else -> FAILED.
REQ-021 STABLE: pll_rst=0; counts consecutive lock=1 cycles; any lock=0 -> WAIT (timeout timer restarted); count reaching STABLE_CYCLES -> LOCKED and retry counter cleared.
REQ-022 LOCKED: locked=1; lock=0 (loss of lock) -> RESET, retry counter unchanged, locked=0 from the next cycle.
REQ-023 FAILED: pll_rst=1, fail=1; held until chan_en=0 or force_rst=1.
REQ-024 Priority per channel: chan_en=0 (-> IDLE next cycle, from any state) > force_rst=1 (-> RESET, retry and fail cleared, from any non-IDLE state) > normal transitions; force_rst in IDLE is ignored.
REQ-025 all_locked SHALL be the AND of locked over channels with chan_en=1, forced 0 when no channel is enabled.
REQ-026 All outputs SHALL be registered; all_locked lags locked by one cycle.
REQ-027 Internal counters SHALL be sized with $clog2 of their parameter plus one bit and SHALL never wrap.

Reset
REQ-028 rst_n=0 at a refclk edge SHALL force every FSM to IDLE, pll_rst all-ones, locked/fail/all_locked zero, all counters, sync flops and lol_count zero.
REQ-029 Reset asserted mid-operation SHALL abort any attempt within that cycle; no partial state survives.
REQ-030 After rst_n returns to 1, enabled channels SHALL enter RESET on the following cycle.

Configuration
REQ-031 Macro FABRIC_PLL_LOL_COUNT_EN selects the loss-of-lock counter feature.
REQ-032 With the macro defined: each LOCKED->RESET transition caused by loss of lock SHALL increment that channel's lol_count by 1, saturating at 255.
REQ-033 lol_count SHALL not change on chan_en/force_rst transitions and is cleared only by rst_n.
REQ-034 Without the macro: no counter logic is built.
REQ-035 The lol_count port exists only when the macro is defined.

Verification (RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRIES=2, NUM_PLLS=2)
REQ-036 chan_en[0]=1, pll_locked_in[0] raised 10 cycles after pll_rst[0] falls -> pll_rst[0] high exactly 4 cycles; locked[0] rises exactly 2+8+1 cycles after pll_locked_in[0] rises.
REQ-037 In STABLE, pll_locked_in[0] drops for 1 cycle at count 5 -> FSM returns to WAIT, locked[0] rises 2+8+1 cycles after lock reasserts.
REQ-038 pll_locked_in[0] held 0 -> three RESET pulses of 4 cycles each separated by 32-cycle waits, then fail[0]=1 with pll_rst[0]=1; force_rst[0] pulse -> fail[0]=0, new 4-cycle reset.
REQ-039 Locked channel, pll_locked_in[0] drops -> locked[0]=0 3 cycles later, new 4-cycle pll_rst[0], relock; with FABRIC_PLL_LOL_COUNT_EN lol_count[7:0]=1.
REQ-040 chan_en=2'b01 with channel 0 locked -> all_locked=1; chan_en=2'b11, channel 1 unlocked -> all_locked=0; rst_n=0 mid-WAIT -> all outputs at reset values the next cycle.
